newton_iter_sequencer: RTL and testbench
========================================

# newton_iter_sequencer

Closed-loop controller on the consumer side of the Broyden/Newton iteration step. It loads initial x and inverse-Jacobian values and presents them to the iteration datapath. It captures the datapath's x and invJ outputs on each valid strobe, checks convergence with an integer ULP-distance test, and feeds the captured state back as the next iteration's input. It finishes on convergence or when the iteration budget is exhausted.

## Interface
- MAX_ITER, 64: iteration budget, 1..65535.
- TOL_ULP, 16: per-component convergence tolerance in float32 ULPs.
- MIN_WAIT, 940: clk cycles after a cur_x update during which iter_stb is ignored (datapath settle guard).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  single-cycle request to begin a solve; sampled only in IDLE.
- init_x  in  96  initial x; x0 in [31:0], x1 in [63:32], x2 in [95:64]; float32 each.
- init_invJ  in  384  initial invJ0..invJ11; invJk in [32k+31:32k].
- iter_x  in  96  out_x0..2 from the iteration datapath, same packing.
- iter_invJ  in  384  next_invJ0..11 from the datapath, same packing.
- iter_stb  in  1  datapath output-valid pulse.
- cur_x  out  96  x presented to the datapath.
- cur_invJ  out  384  invJ presented to the datapath.
- result_x  out  96  final x; held until the next accepted start.
- iter_count  out  16  iterations accepted in the current or last solve.
- busy  out  1  high from LOAD through CHECK.
- done  out  1  one-cycle pulse at solve end.
- converged  out  1  valid with done; held until the next accepted start.
- aborted  out  1  non-finite abort flag; held until the next accepted start; constant 0 without the macro.

## Operation
- States: IDLE, LOAD, WAIT, CHECK, DONE.
- IDLE:
  - start=1 → LOAD.
  - Clear iter_count, converged and aborted.
- LOAD:
  - cur_x <= init_x, cur_invJ <= init_invJ, guard counter <= 0.
  - → WAIT.
- WAIT:
  - Guard counter (16-bit) increments and saturates at MIN_WAIT.
  - iter_stb=1 with guard == MIN_WAIT: cap_x <= iter_x, cap_invJ <= iter_invJ, iter_count++, → CHECK.
  - iter_stb while guard < MIN_WAIT is dropped.
- CHECK (one cycle), for each component i:
  - ord(v) = v[31] ? 32'h8000_0000 - v[30:0] : 32'h8000_0000 | v[30:0], so +0 and -0 are equal.
  - d_i = |ord(cap_x_i) - ord(cur_x_i)|, unsigned 32-bit.
  - All d_i <= TOL_ULP: converged <= 1, result_x <= cap_x, → DONE.
  - Otherwise, if iter_count == MAX_ITER: converged <= 0, result_x <= cap_x, → DONE.
  - Otherwise: cur_x <= cap_x, cur_invJ <= cap_invJ, guard <= 0, → WAIT.
- DONE: done=1 for this cycle only, → IDLE.
- start outside IDLE is ignored. iter_stb outside WAIT is ignored.
- Simultaneous start and rst=0: reset wins.

## Timing
- Reset: all outputs and state go to 0 and the FSM enters IDLE, one edge after rst=0 is sampled. Applies from any state, including mid-solve.
- start sampled at edge t: LOAD at t+1. cur_x is valid and busy=1 from t+2, when the FSM is in WAIT.
- Accepted strobe at edge s: CHECK at s+1.
  - Next cur_x is visible at s+2.
  - Or done=1 at s+2 when finishing.
- The earliest accepted strobe after any cur_x update comes MIN_WAIT cycles after entering WAIT.
- busy drops in the DONE cycle. start is accepted again at the following edge.

## Configuration
- NR_SEQ_NAN_ABORT_EN defined:
  - In CHECK, if any cap_x component has exponent 8'hFF (NaN/Inf): aborted <= 1, converged <= 0, result_x <= cur_x (last finite x), → DONE.
  - This test takes priority over the convergence and budget tests.
- NR_SEQ_NAN_ABORT_EN undefined:
  - No abort logic; aborted is tied to 0.
  - Non-finite values are compared by ordinal like any other value and normally fail the tolerance, so the solve continues until the budget is reached.

## Test plan
- Converging solve: init_x=(1.0,1.0,1.0); the datapath model returns 32'h3F80_0010 for each component on the first strobe → converged=1, iter_count=1, result_x equals the captured values, done pulse exactly one cycle.
- Budget exhaustion: MAX_ITER=4; each strobe returns x incremented by 2.0 → 4 iterations, converged=0, iter_count=4, result_x = init+8.0.
- Early strobe guard: MIN_WAIT=940; pulse iter_stb at guard 100 and again at guard 940 → only the second is captured; iter_count increments once.
- Signed zero: cur_x=(+0,+0,+0), strobe returns (-0,-0,-0) with TOL_ULP=0 → converged=1.
- NaN: strobe returns x0=32'h7FC0_0000.
  - With NR_SEQ_NAN_ABORT_EN: aborted=1, converged=0, result_x=previous cur_x.
  - Without the macro: the solve continues until MAX_ITER.
- Reset mid-WAIT: rst=0 for one cycle at iteration 3 → all outputs 0 next edge, state IDLE; a subsequent start restarts with iter_count=0.

Source files
------------

// File: rtl/newton_iter_sequencer.sv
// Consumer-side sequencer for a Newton/Broyden iteration datapath: loads the initial state, feeds
// back captured outputs and stops on ULP convergence or budget. NR_SEQ_NAN_ABORT_EN adds a NaN/Inf abort.
module newton_iter_sequencer #(
    parameter int unsigned MAX_ITER = 64,
    parameter int unsigned TOL_ULP  = 16,
    parameter int unsigned MIN_WAIT = 940
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [95:0]  init_x,
    input  logic [383:0] init_invJ,
    input  logic [95:0]  iter_x,
    input  logic [383:0] iter_invJ,
    input  logic         iter_stb,
    output logic [95:0]  cur_x,
    output logic [383:0] cur_invJ,
    output logic [95:0]  result_x,
    output logic [15:0]  iter_count,
    output logic         busy,
    output logic         done,
    output logic         converged,
    output logic         aborted
);

    typedef enum logic [2:0] {StIdle, StLoad, StWait, StCheck, StDone} state_e;

    localparam logic [15:0] MinWait = 16'(MIN_WAIT);
    localparam logic [15:0] MaxIter = 16'(MAX_ITER);
    localparam logic [31:0] TolUlp  = 32'(TOL_ULP);

    state_e         state_q, state_d;
    logic [95:0]    cur_x_q, cur_x_d;
    logic [383:0]   cur_invj_q, cur_invj_d;
    logic [95:0]    cap_x_q, cap_x_d;
    logic [383:0]   cap_invj_q, cap_invj_d;
    logic [95:0]    result_x_q, result_x_d;
    logic [15:0]    guard_q, guard_d;
    logic [15:0]    iter_count_q, iter_count_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           converged_q, converged_d;
`ifdef NR_SEQ_NAN_ABORT_EN
    logic           aborted_q, aborted_d;
    logic           cap_non_finite;
`endif
    logic           within_tol;

    // Sign-magnitude float mapped onto a monotonic unsigned line; +0 and -0 share one point.
    function automatic logic [31:0] ord(input logic [31:0] v);
        ord = v[31] ? (32'h8000_0000 - {1'b0, v[30:0]}) : {1'b1, v[30:0]};
    endfunction

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        within_tol = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (abs_diff(ord(cap_x_q[32*i +: 32]), ord(cur_x_q[32*i +: 32])) > TolUlp) begin
                within_tol = 1'b0;
            end
        end
    end

`ifdef NR_SEQ_NAN_ABORT_EN
    always_comb begin
        cap_non_finite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (cap_x_q[32*i+23 +: 8] == 8'hFF) begin
                cap_non_finite = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cur_x_d      = cur_x_q;
        cur_invj_d   = cur_invj_q;
        cap_x_d      = cap_x_q;
        cap_invj_d   = cap_invj_q;
        result_x_d   = result_x_q;
        guard_d      = guard_q;
        iter_count_d = iter_count_q;
        converged_d  = converged_q;
`ifdef NR_SEQ_NAN_ABORT_EN
        aborted_d    = aborted_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    iter_count_d = 16'd0;
                    converged_d  = 1'b0;
`ifdef NR_SEQ_NAN_ABORT_EN
                    aborted_d    = 1'b0;
`endif
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                cur_x_d    = init_x;
                cur_invj_d = init_invJ;
                guard_d    = 16'd0;
                state_d    = StWait;
            end
            StWait: begin
                if (guard_q != MinWait) begin
                    guard_d = guard_q + 16'd1;
                end
                // Strobes before the settle guard expires belong to a stale input and are dropped.
                if (iter_stb && (guard_q == MinWait)) begin
                    cap_x_d      = iter_x;
                    cap_invj_d   = iter_invJ;
                    iter_count_d = iter_count_q + 16'd1;
                    state_d      = StCheck;
                end
            end
            StCheck: begin
`ifdef NR_SEQ_NAN_ABORT_EN
                if (cap_non_finite) begin
                    aborted_d   = 1'b1;
                    converged_d = 1'b0;
                    result_x_d  = cur_x_q;
                    state_d     = StDone;
                end else
`endif
                if (within_tol) begin
                    converged_d = 1'b1;
                    result_x_d  = cap_x_q;
                    state_d     = StDone;
                end else if (iter_count_q == MaxIter) begin
                    converged_d = 1'b0;
                    result_x_d  = cap_x_q;
                    state_d     = StDone;
                end else begin
                    cur_x_d    = cap_x_q;
                    cur_invj_d = cap_invj_q;
                    guard_d    = 16'd0;
                    state_d    = StWait;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StLoad) || (state_d == StWait) || (state_d == StCheck);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cur_x_q      <= '0;
            cur_invj_q   <= '0;
            cap_x_q      <= '0;
            cap_invj_q   <= '0;
            result_x_q   <= '0;
            guard_q      <= '0;
            iter_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            converged_q  <= 1'b0;
`ifdef NR_SEQ_NAN_ABORT_EN
            aborted_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cur_x_q      <= cur_x_d;
            cur_invj_q   <= cur_invj_d;
            cap_x_q      <= cap_x_d;
            cap_invj_q   <= cap_invj_d;
            result_x_q   <= result_x_d;
            guard_q      <= guard_d;
            iter_count_q <= iter_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            converged_q  <= converged_d;
`ifdef NR_SEQ_NAN_ABORT_EN
            aborted_q    <= aborted_d;
`endif
        end
    end

    assign cur_x      = cur_x_q;
    assign cur_invJ   = cur_invj_q;
    assign result_x   = result_x_q;
    assign iter_count = iter_count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign converged  = converged_q;
`ifdef NR_SEQ_NAN_ABORT_EN
    assign aborted    = aborted_q;
`else
    assign aborted    = 1'b0;
`endif

endmodule

// File: tb/tb_newton_iter_sequencer.sv
// Scoreboard bench for newton_iter_sequencer: directed solves queue their expected outcome and a
// negedge monitor checks it whenever done pulses.
module tb_newton_iter_sequencer;

    localparam int unsigned MaxIter = 4;
    localparam int unsigned TolUlp  = 16;
    localparam int unsigned MinWait = 940;

    localparam logic [31:0] F1  = 32'h3F80_0000;  // 1.0
    localparam logic [31:0] F2  = 32'h4000_0000;  // 2.0
    localparam logic [31:0] F3  = 32'h4040_0000;  // 3.0
    localparam logic [31:0] F5  = 32'h40A0_0000;  // 5.0
    localparam logic [31:0] F7  = 32'h40E0_0000;  // 7.0
    localparam logic [31:0] F9  = 32'h4110_0000;  // 9.0
    localparam logic [31:0] FM1 = 32'hBF80_0000;  // -1.0
    localparam logic [31:0] NAN = 32'h7FC0_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         iter_stb = 1'b0;
    logic [95:0]  init_x = '0;
    logic [95:0]  iter_x = '0;
    logic [383:0] init_invJ = '0;
    logic [383:0] iter_invJ = '0;
    logic [95:0]  cur_x;
    logic [383:0] cur_invJ;
    logic [95:0]  result_x;
    logic [15:0]  iter_count;
    logic         busy;
    logic         done;
    logic         converged;
    logic         aborted;

    always #5 clk = ~clk;

    newton_iter_sequencer #(
        .MAX_ITER(MaxIter),
        .TOL_ULP (TolUlp),
        .MIN_WAIT(MinWait)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .init_x    (init_x),
        .init_invJ (init_invJ),
        .iter_x    (iter_x),
        .iter_invJ (iter_invJ),
        .iter_stb  (iter_stb),
        .cur_x     (cur_x),
        .cur_invJ  (cur_invJ),
        .result_x  (result_x),
        .iter_count(iter_count),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .aborted   (aborted)
    );

    typedef struct packed {
        logic        conv;
        logic        abrt;
        logic [15:0] cnt;
        logic [95:0] rx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   done_base = 0;
    int   g_now = 0;
    logic chk_done_low = 1'b0;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [383:0] mk_invj(input logic [31:0] b);
        logic [383:0] r;
        for (int k = 0; k < 12; k++) r[32*k +: 32] = b + 32'(k);
        return r;
    endfunction

    function automatic logic [95:0] vec3(input logic [31:0] a);
        return {a, a, a};
    endfunction

    // Monitor: pops one expected outcome per done pulse.
    always @(negedge clk) begin : mon
        exp_t e;
        if (chk_done_low) check("done_one_cycle", done, 1'b0);
        chk_done_low <= 1'b0;
        if (done === 1'b1) begin
            done_seen++;
            chk_done_low <= 1'b1;
            check("busy_in_done", busy, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 want no done");
            end else begin
                e = exp_q.pop_front();
                check("converged", converged, e.conv);
                check("aborted", aborted, e.abrt);
                check("iter_count", iter_count, e.cnt);
                check("result_x", result_x, e.rx);
            end
        end
    end

    task automatic push_exp(input logic c, input logic a, input logic [15:0] n,
                            input logic [95:0] rx);
        exp_t e;
        e.conv = c;
        e.abrt = a;
        e.cnt  = n;
        e.rx   = rx;
        exp_q.push_back(e);
    endtask

    task automatic start_solve(input logic [95:0] x, input logic [383:0] ij);
        done_base = done_seen;
        init_x    = x;
        init_invJ = ij;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        g_now = 0;
        check("load_cur_x", cur_x, x);
        check("load_cur_invJ", cur_invJ, ij);
        check("load_busy", busy, 1'b1);
        check("load_iter_count", iter_count, 16'd0);
    endtask

    // Present a strobe so the DUT samples it with its guard counter equal to g.
    task automatic strobe(input int g, input logic [95:0] x, input logic [383:0] ij,
                          input bit last);
        while (g_now < g) begin
            @(posedge clk); #1;
            g_now++;
        end
        iter_x    = x;
        iter_invJ = ij;
        iter_stb  = 1'b1;
        @(posedge clk); #1;
        iter_stb = 1'b0;
        if (g >= int'(MinWait)) begin
            if (!last) begin
                @(posedge clk); #1;
                g_now = 0;
                check("feedback_cur_x", cur_x, x);
                check("feedback_cur_invJ", cur_invJ, ij);
            end
        end else begin
            g_now = g + 1;
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done_seen > done_base) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done want done within 10 cycles");
        end
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] steps[4];
        steps = '{F3, F5, F7, F9};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cur_x", cur_x, 96'd0);
        check("rst_cur_invJ", cur_invJ, 384'd0);
        check("rst_result_x", result_x, 96'd0);
        check("rst_flags", {busy, done, converged, aborted, iter_count}, 20'd0);
        rst = 1'b1;

        // Converging solve: 16 ULPs away from 1.0 sits on the tolerance edge.
        start_solve(vec3(F1), mk_invj(32'h1000_0000));
        push_exp(1'b1, 1'b0, 16'd1, vec3(32'h3F80_0010));
        strobe(MinWait, vec3(32'h3F80_0010), mk_invj(32'h2000_0000), 1'b1);
        wait_done();

        // Early strobes (guard 100 and MinWait-1) carry far values and must be dropped.
        start_solve(vec3(F1), mk_invj(32'h1000_0000));
        strobe(100, vec3(32'h42C8_0000), mk_invj(32'h3000_0000), 1'b0);
        check("guard100_dropped", iter_count, 16'd0);
        strobe(MinWait - 1, vec3(32'h42C8_0000), mk_invj(32'h3000_0000), 1'b0);
        check("guard939_dropped", iter_count, 16'd0);
        push_exp(1'b1, 1'b0, 16'd1, vec3(32'h3F80_000F));
        strobe(MinWait, vec3(32'h3F80_000F), mk_invj(32'h4000_0000), 1'b1);
        wait_done();

        // Signed zero: -0 against +0 is distance 0.
        start_solve(vec3(32'h0), mk_invj(32'h0));
        push_exp(1'b1, 1'b0, 16'd1, vec3(32'h8000_0000));
        strobe(MinWait, vec3(32'h8000_0000), mk_invj(32'h5000_0000), 1'b1);
        wait_done();

        // Negative values: 17 ULPs fails, then 16 ULPs converges.
        start_solve({F1, FM1, FM1}, mk_invj(32'h0100_0000));
        strobe(MinWait, {F1, FM1, 32'hBF80_0011}, mk_invj(32'h0200_0000), 1'b0);
        push_exp(1'b1, 1'b0, 16'd2, {F1, FM1, 32'hBF80_0001});
        strobe(MinWait, {F1, FM1, 32'hBF80_0001}, mk_invj(32'h0300_0000), 1'b1);
        wait_done();

        // Budget exhaustion, with a start pulse mid-solve that must be ignored.
        start_solve(vec3(F1), mk_invj(32'h0400_0000));
        strobe(MinWait, vec3(steps[0]), mk_invj(32'h0500_0000), 1'b0);
        init_x = '0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        g_now++;
        check("start_ignored_cur_x", cur_x, vec3(F3));
        strobe(MinWait, vec3(steps[1]), mk_invj(32'h0600_0000), 1'b0);
        strobe(MinWait, vec3(steps[2]), mk_invj(32'h0700_0000), 1'b0);
        push_exp(1'b0, 1'b0, 16'd4, vec3(F9));
        strobe(MinWait, vec3(steps[3]), mk_invj(32'h0800_0000), 1'b1);
        wait_done();

        // Non-finite component in the datapath output.
        start_solve(vec3(F1), mk_invj(32'h0900_0000));
`ifdef NR_SEQ_NAN_ABORT_EN
        push_exp(1'b0, 1'b1, 16'd1, vec3(F1));
        strobe(MinWait, {F3, F3, NAN}, mk_invj(32'h0A00_0000), 1'b1);
`else
        for (int i = 0; i < 3; i++) begin
            strobe(MinWait, {steps[i], steps[i], NAN}, mk_invj(32'h0A00_0000), 1'b0);
        end
        push_exp(1'b0, 1'b0, 16'd4, {F9, F9, NAN});
        strobe(MinWait, {F9, F9, NAN}, mk_invj(32'h0B00_0000), 1'b1);
`endif
        wait_done();

        // One-cycle reset while waiting in iteration 3, then a clean restart.
        start_solve(vec3(F1), mk_invj(32'h0C00_0000));
        strobe(MinWait, vec3(F3), mk_invj(32'h0D00_0000), 1'b0);
        strobe(MinWait, vec3(F5), mk_invj(32'h0E00_0000), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_cur_x", cur_x, 96'd0);
        check("midrst_cur_invJ", cur_invJ, 384'd0);
        check("midrst_result_x", result_x, 96'd0);
        check("midrst_flags", {busy, done, converged, aborted, iter_count}, 20'd0);
        start_solve(vec3(F2), mk_invj(32'h0F00_0000));
        push_exp(1'b1, 1'b0, 16'd1, vec3(32'h4000_0005));
        strobe(MinWait, vec3(32'h4000_0005), mk_invj(32'h1100_0000), 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 384'(exp_q.size()), 384'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
